// File: rtl/spi_pkg.sv
// Shared types and frame constants for the SPI master and its SCLK timing helper.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_t;

    localparam logic SPI_CMD_READ   = 1'b1;
    localparam logic SPI_CMD_WRITE  = 1'b0;
    localparam int   SPI_FRAME_BITS = 16;
    localparam int   SPI_ADDR_W     = 7;
    localparam int   SPI_DATA_W     = 8;

    function automatic logic [SPI_FRAME_BITS-1:0] spi_pack_frame(
        input logic [SPI_ADDR_W-1:0] addr,
        input logic                  rw,
        input logic [SPI_DATA_W-1:0] data
    );
        return {addr, rw, data};
    endfunction

endpackage

// File: rtl/spi_sclk_tick.sv
// SCLK half-period timer: counts CLK_DIV clk cycles per phase and toggles SCLK
// only while shifting; half/rise/fall strobes mark the clk edge ending a phase.
module spi_sclk_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    input  logic shift_i,
    output logic sclk_o,
    output logic half_tick_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             half_tick, rise_tick, fall_tick;

    always_comb begin
        half_tick = en_i && (cnt_q == '0);
        rise_tick = half_tick && shift_i && !sclk_q;
        fall_tick = half_tick && sclk_q;

        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (clr_i) begin
            cnt_d  = RELOAD;
            sclk_d = 1'b0;
        end else begin
            if (en_i) begin
                cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CNT_W'(1);
            end
            if (rise_tick) begin
                sclk_d = 1'b1;
            end else if (fall_tick) begin
                sclk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q  <= RELOAD;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o      = sclk_q;
    assign half_tick_o = half_tick;
    assign rise_tick_o = rise_tick;
    assign fall_tick_o = fall_tick;

endmodule

// File: rtl/spi_master.sv
// SPI master for 16-bit {addr, rw, data} frames with registered pin outputs.
// Define SPI_MASTER_LOOPBACK_EN to read back the transmitted byte instead of MISO.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8,
    parameter int ADDR_W  = SPI_ADDR_W,
    parameter int DATA_W  = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk_pin,
    output logic              cs_pin,
    output logic              mosi_pin,
    input  logic              miso_pin
);

    localparam int FRAME_W = ADDR_W + 1 + DATA_W;
    localparam int GAP_W   = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [4:0]       BIT_END    = 5'(FRAME_W);
    localparam logic [4:0]       DATA_FIRST = 5'(ADDR_W + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(CS_GAP - 1);

    spi_state_t         state_q, state_d;
    logic [4:0]         bit_q, bit_d;
    logic [4:0]         bit_next;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [FRAME_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rw_q, rw_d;
    logic               cs_q, cs_d;
    logic               mosi_q, mosi_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;

    logic tick_clr, tick_en, tick_shift;
    logic sclk_w, half_tick, rise_tick, fall_tick;
    logic miso_src, tx_mask;

    assign tick_clr   = (state_q == IDLE);
    assign tick_en    = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
    assign tick_shift = (state_q == SHIFT);
    assign bit_next   = bit_q + 5'd1;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso_pin;
    assign miso_src    = mosi_q;
    assign tx_mask     = 1'b0;
`else
    assign miso_src = miso_pin;
    // Read frames send zeros in the data byte so the slave sees a clean command.
    assign tx_mask  = (rw_q == SPI_CMD_READ) && (bit_next >= DATA_FIRST);
`endif

    spi_sclk_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_tick (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (tick_clr),
        .en_i       (tick_en),
        .shift_i    (tick_shift),
        .sclk_o     (sclk_w),
        .half_tick_o(half_tick),
        .rise_tick_o(rise_tick),
        .fall_tick_o(fall_tick)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        rw_d    = rw_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cs_d   = 1'b1;
                mosi_d = 1'b0;
                if (start) begin
                    sh_d    = {addr, rw, wdata};
                    rw_d    = rw;
                    mosi_d  = addr[ADDR_W-1];
                    cs_d    = 1'b0;
                    bit_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (half_tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // MISO is sampled on the clk edge that raises SCLK.
                if (rise_tick && (rw_q == SPI_CMD_READ) && (bit_q >= DATA_FIRST)) begin
                    rx_d = {rx_q[DATA_W-2:0], miso_src};
                end
                if (fall_tick) begin
                    bit_d = bit_next;
                    if (bit_next == BIT_END) begin
                        mosi_d  = 1'b0;
                        state_d = HOLD;
                    end else begin
                        sh_d   = {sh_q[FRAME_W-2:0], 1'b0};
                        mosi_d = sh_q[FRAME_W-2] & ~tx_mask;
                    end
                end
            end
            HOLD: begin
                if (half_tick) begin
                    cs_d    = 1'b1;
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    if (rw_q == SPI_CMD_READ) begin
                        rdata_d = rx_q;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            bit_q   <= '0;
            gap_q   <= '0;
            rw_q    <= SPI_CMD_WRITE;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            rw_q    <= rw_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        sh_q <= sh_d;
        rx_q <= rx_d;
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign sclk_pin = sclk_w;
    assign cs_pin   = cs_q;
    assign mosi_pin = mosi_q;

endmodule
